hex_rate_counter: RTL

//  Two-digit (8-bit) hex counter advanced by a built-in rate divider; the stage directly upstream
//  of the per-digit 7-segment decoders. Each 4-bit digit output drives one decoder's c[3:0] input.

---
 rtl/hex_rate_counter_pkg.sv | 10 +
 rtl/hex_rate_counter_if.sv | 13 +
 rtl/hex_rate_counter_rate_divider.sv | 31 +++
 rtl/hex_rate_counter.sv | 33 +++
 4 files changed

// File: rtl/hex_rate_counter_pkg.sv
// display_pkg: speed codes and divider period shared across the display path.
package display_pkg;
  localparam logic [1:0] SPD_FAST = 2'b00;
  localparam logic [1:0] SPD_1HZ  = 2'b01;
  localparam logic [1:0] SPD_HALF = 2'b10;
  localparam logic [1:0] SPD_QTR  = 2'b11;
  function automatic logic [31:0] period(input logic [1:0] s, input int unsigned f);
    return s == SPD_FAST ? 32'd1 : s == SPD_1HZ ? f : s == SPD_HALF ? 2 * f : 4 * f;
  endfunction
endpackage

// File: rtl/hex_rate_counter_if.sv
// hex_rate_counter_if: control inputs and digit/tick outputs of the hex rate counter.
interface hex_rate_counter_if;
  logic       enable;
  logic [1:0] speed;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic       tick;
  modport master (output enable, speed, up, load, load_val, input digit0, digit1, tick);
  modport slave  (input enable, speed, up, load, load_val, output digit0, digit1, tick);
endinterface

// File: rtl/hex_rate_counter_rate_divider.sv
// rate_divider: down-counting divider emitting a step when a full period of enabled cycles elapses.
module rate_divider
  import display_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       reload,
  output logic       step
);
  localparam int W = $clog2(4 * CLK_FREQ);
  logic [W-1:0] r_rd_cnt;
  logic [1:0]   r_spd_q;
  logic [W-1:0] w_top_new;
  logic [W-1:0] w_top_cur;
  assign w_top_new = W'(period(speed, CLK_FREQ) - 32'd1);
  assign w_top_cur = W'(period(r_spd_q, CLK_FREQ) - 32'd1);
  assign step = enable & ~reload & (speed == r_spd_q) & (r_rd_cnt == '0);
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_rd_cnt <= '0;
      r_spd_q  <= SPD_FAST;
    end else if (reload || speed != r_spd_q) begin
      r_rd_cnt <= w_top_new;
      r_spd_q  <= speed;
    end else if (enable)
      r_rd_cnt <= r_rd_cnt == '0 ? w_top_cur : r_rd_cnt - W'(1);
endmodule

// File: rtl/hex_rate_counter.sv
// hex_rate_counter: two-digit hex counter advanced by rate_divider, feeding the 7-segment decoders.
module hex_rate_counter
  import display_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input logic clock,
  input logic resetn,
  hex_rate_counter_if.slave bus
);
  logic [7:0] r_count;
  logic       r_tick;
  logic       w_step;
  rate_divider #(.CLK_FREQ(CLK_FREQ)) u_div (
    .clock  (clock),
    .resetn (resetn),
    .enable (bus.enable),
    .speed  (bus.speed),
    .reload (bus.load),
    .step   (w_step)
  );
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_count <= 8'h00;
      r_tick  <= 1'b0;
    end else begin
      r_count <= bus.load ? bus.load_val : w_step ? (bus.up ? r_count + 8'd1 : r_count - 8'd1) : r_count;
      r_tick  <= w_step;
    end
  assign bus.digit0 = r_count[3:0];
  assign bus.digit1 = r_count[7:4];
  assign bus.tick   = r_tick;
endmodule
